wishbone_rom_arbiter: RTL
=========================

Name: wishbone_rom_arbiter

Overview:
Two-master Wishbone arbiter sharing the single data port of the boot/instruction ROM slave. Master 0 is the core load/store unit; master 1 is the debug/loader port. It sits between both masters and the ROM slave's i_ADDR/o_DATA/i_SEL/i_STB/o_ACK/i_CYC/i_TAGN/o_TAGN port. It grants one master per Wishbone cycle, using round-robin on contention. The ROM fetch port (PC/instruction) is not touched.

Parameters:
DATA_WIDTH, 32, data bus width
ADDR_WIDTH, 32, address bus width
TIMEOUT_CYCLES, 16, STB-without-ACK cycles before abort (used only with WB_ARB_TIMEOUT_EN)

Ports:
i_CLK  in  1  single clock; all state updates on rising edge
i_RST  in  1  synchronous, active-high reset
i_M0_ADDR, i_M1_ADDR  in  ADDR_WIDTH  master byte address
i_M0_SEL, i_M1_SEL  in  4  byte select
i_M0_STB, i_M1_STB  in  1  strobe
i_M0_CYC, i_M1_CYC  in  1  cycle valid / bus request
i_M0_TAGN, i_M1_TAGN  in  1  master tag
o_M0_DATA, o_M1_DATA  out  DATA_WIDTH  read data
o_M0_ACK, o_M1_ACK  out  1  acknowledge
o_M0_ERR, o_M1_ERR  out  1  error/abort (tied 0 without WB_ARB_TIMEOUT_EN)
o_M0_TAGN, o_M1_TAGN  out  1  slave tag returned
o_S_ADDR  out  ADDR_WIDTH  to slave
o_S_SEL  out  4  to slave
o_S_STB, o_S_CYC, o_S_TAGN  out  1  to slave
i_S_DATA  in  DATA_WIDTH  from slave
i_S_ACK, i_S_TAGN  in  1  from slave

Behaviour:
- FSM states: IDLE, GNT0, GNT1. Grant is registered; a request seen in IDLE is forwarded from the next cycle (1-cycle arbitration latency).
- Round-robin pointer `last`: 1 bit, holds the last granted master. Reset value 1, so M0 wins the first contention.
- IDLE: only M0 CYC -> GNT0. Only M1 CYC -> GNT1. Both -> grant the master != last. Neither -> stay in IDLE.
- On entry to GNTx: last <= x.
- GNTx, forwarding: o_S_ADDR/SEL/STB/TAGN = master x inputs; o_S_CYC = i_Mx_CYC (combinational). Slave ACK, DATA and TAGN route to master x only.
- GNTx, non-granted master: ACK=0, DATA=0, TAGN=0.
- GNTx is held while i_Mx_CYC=1, so multiple STB/ACK transfers are allowed within one cycle.
- GNTx release: i_Mx_CYC=0 -> IDLE next cycle. There is no direct GNT0->GNT1 hop; the IDLE cycle guarantees o_S_CYC deasserts for at least 1 cycle between owners.
- IDLE outputs: all slave outputs 0; all master ACK/ERR/DATA/TAGN 0.
- ACK is never forwarded when the owner's STB=0. o_Mx_ACK = i_S_ACK & i_Mx_STB & grant.
- Reset values: state=IDLE, last=1, timeout counter=0. All o_S_* and o_Mx_ACK/ERR are 0 in the cycle after the reset edge.
- Reset mid-cycle: an in-flight transfer is dropped; masters retry.
- Simultaneous release by owner and new request: release is seen first, then arbitration in IDLE the following cycle.

Optional Feature:
Macro WB_ARB_TIMEOUT_EN.
- Defined: counter increments while in GNTx with o_S_STB=1 and i_S_ACK=0; it clears on ACK or state change.
- Defined, on reaching TIMEOUT_CYCLES: o_Mx_ERR=1 for exactly 1 cycle, o_S_CYC/STB forced 0 that cycle, and state -> IDLE.
- Not defined: no counter exists; o_M0_ERR and o_M1_ERR are constant 0; no abort path.

Test Plan:
1. M0 only: CYC/STB with addr 0x10, slave acks with 0xDEADBEEF. -> o_S_CYC rises 1 cycle after request, o_S_ADDR=0x10, o_M0_DATA=0xDEADBEEF with o_M0_ACK=1, o_M1_ACK=0.
2. Both CYC rise together after reset. -> GNT0 first; M0 drops CYC after 1 ACK; 1 IDLE cycle with o_S_CYC=0; then GNT1 with o_S_ADDR = M1 address.
3. Both request continuously, each dropping CYC after every ACK. -> grant order 0,1,0,1 over 4 transfers.
4. M0 holds CYC across 3 STB transfers (addr 0x0, 0x4, 0x8) while M1 requests. -> 3 ACKs to M0; M1 gets no ACK until 2 cycles after M0 CYC falls.
5. i_RST pulsed during GNT1 mid-transfer. -> next cycle state IDLE, o_S_CYC=0, o_M1_ACK=0; then with both requesting, M0 is granted.
6. WB_ARB_TIMEOUT_EN defined, M0 STB held, i_S_ACK=0 for 16 cycles. -> o_M0_ERR=1 on the 16th cycle for 1 cycle, o_S_CYC=0, FSM=IDLE. Without the macro, o_M0_ERR stays 0 and the grant is held.

Source files
------------

// File: rtl/wishbone_rom_arbiter.sv
// Two-master Wishbone arbiter in front of the boot/instruction ROM data port.
// Master 0 is the load/store unit, master 1 is the debug/loader port. One
// master owns the slave per Wishbone cycle. Round-robin decides contention.
// Optional build macro: WB_ARB_TIMEOUT_EN adds a stalled-strobe abort path
// that raises o_Mx_ERR after TIMEOUT_CYCLES cycles without ACK.
module wishbone_rom_arbiter #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,

    input  logic [ADDR_WIDTH-1:0] i_M0_ADDR,
    input  logic [3:0]            i_M0_SEL,
    input  logic                  i_M0_STB,
    input  logic                  i_M0_CYC,
    input  logic                  i_M0_TAGN,
    output logic [DATA_WIDTH-1:0] o_M0_DATA,
    output logic                  o_M0_ACK,
    output logic                  o_M0_ERR,
    output logic                  o_M0_TAGN,

    input  logic [ADDR_WIDTH-1:0] i_M1_ADDR,
    input  logic [3:0]            i_M1_SEL,
    input  logic                  i_M1_STB,
    input  logic                  i_M1_CYC,
    input  logic                  i_M1_TAGN,
    output logic [DATA_WIDTH-1:0] o_M1_DATA,
    output logic                  o_M1_ACK,
    output logic                  o_M1_ERR,
    output logic                  o_M1_TAGN,

    output logic [ADDR_WIDTH-1:0] o_S_ADDR,
    output logic [3:0]            o_S_SEL,
    output logic                  o_S_STB,
    output logic                  o_S_CYC,
    output logic                  o_S_TAGN,
    input  logic [DATA_WIDTH-1:0] i_S_DATA,
    input  logic                  i_S_ACK,
    input  logic                  i_S_TAGN
);

    localparam int unsigned SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t                state;
    state_t                next_state;
    logic                  last;
    logic                  last_next;

    logic                  granted;
    logic                  owner;
    logic                  pick;
    logic [ADDR_WIDTH-1:0] own_addr;
    logic [SEL_W-1:0]      own_sel;
    logic                  own_stb;
    logic                  own_cyc;
    logic                  own_tagn;
    logic                  abort_c;

    // A zero timeout would make the abort path meaningless.
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("wishbone_rom_arbiter: TIMEOUT_CYCLES must be nonzero");
    end

    // Owner decode from the registered grant.
    assign granted = (state == GNT0) || (state == GNT1);
    assign owner   = (state == GNT1);

    // Request signals of whichever master currently owns the slave.
    always_comb begin
        own_addr = i_M0_ADDR;
        own_sel  = i_M0_SEL;
        own_stb  = i_M0_STB;
        own_cyc  = i_M0_CYC;
        own_tagn = i_M0_TAGN;
        if (owner) begin
            own_addr = i_M1_ADDR;
            own_sel  = i_M1_SEL;
            own_stb  = i_M1_STB;
            own_cyc  = i_M1_CYC;
            own_tagn = i_M1_TAGN;
        end
    end

    // Arbitration pick: a lone requester wins, contention goes to the master
    // that was not granted last.
    always_comb begin
        pick = i_M1_CYC;
        if (i_M0_CYC && i_M1_CYC) begin
            pick = ~last;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] to_cnt;
    logic             stall_c;

    assign stall_c = granted & own_stb & ~i_S_ACK;
    // Abort on the TIMEOUT_CYCLES-th consecutive stalled strobe cycle.
    assign abort_c = stall_c & (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Stall counter: clears on ACK or any grant change, counts stalled strobes.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            to_cnt <= '0;
        end else if ((next_state != state) || i_S_ACK) begin
            to_cnt <= '0;
        end else if (stall_c) begin
            to_cnt <= to_cnt + CNT_W'(1);
        end
    end
`else
    assign abort_c = 1'b0;
`endif

    // Grant state and round-robin pointer.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= next_state;
            last  <= last_next;
        end
    end

    // Next grant and steering of the slave port and both return paths.
    always_comb begin
        next_state = state;
        last_next  = last;

        o_S_ADDR   = '0;
        o_S_SEL    = '0;
        o_S_STB    = 1'b0;
        o_S_CYC    = 1'b0;
        o_S_TAGN   = 1'b0;

        o_M0_DATA  = '0;
        o_M0_ACK   = 1'b0;
        o_M0_ERR   = 1'b0;
        o_M0_TAGN  = 1'b0;
        o_M1_DATA  = '0;
        o_M1_ACK   = 1'b0;
        o_M1_ERR   = 1'b0;
        o_M1_TAGN  = 1'b0;

        case (state)
            IDLE: begin
                if (i_M0_CYC || i_M1_CYC) begin
                    next_state = pick ? GNT1 : GNT0;
                    last_next  = pick;
                end
            end

            GNT0, GNT1: begin
                o_S_ADDR = own_addr;
                o_S_SEL  = own_sel;
                o_S_STB  = own_stb;
                o_S_CYC  = own_cyc;
                o_S_TAGN = own_tagn;

                // Return path only to the owner; ACK gated by its own strobe.
                if (owner) begin
                    o_M1_DATA = i_S_DATA;
                    o_M1_ACK  = i_S_ACK & i_M1_STB;
                    o_M1_TAGN = i_S_TAGN;
                end else begin
                    o_M0_DATA = i_S_DATA;
                    o_M0_ACK  = i_S_ACK & i_M0_STB;
                    o_M0_TAGN = i_S_TAGN;
                end

                // Release always passes through IDLE so CYC drops between owners.
                if (!own_cyc) begin
                    next_state = IDLE;
                end

                // Stalled slave: drop the cycle and flag the owner for one cycle.
                if (abort_c && granted) begin
                    o_S_CYC    = 1'b0;
                    o_S_STB    = 1'b0;
                    next_state = IDLE;
                    if (owner) begin
                        o_M1_ERR = 1'b1;
                    end else begin
                        o_M0_ERR = 1'b1;
                    end
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule
